// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: FSM state encoding, default reset PC and the canonical NOP.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, inst} entries; head is the oldest entry.
// Flush has priority over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [63:0]      wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic [63:0]      head_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, drives the 1-cycle ROM and buffers words for decode.
// Build macro FETCH_PERF_EN adds the perf_bubble_cnt / perf_flush_cnt counter outputs.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int          ADDR_W     = 14,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inflight_pc_q;
    logic             inflight_q;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_head;
    logic             redirect_act, pop, issue, push, kill, has_room;
    logic             unused_bits;

    assign unused_bits = ^{redirect_pc[1:0], INST_NOP};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_act),
        .wdata_i ({inflight_pc_q, rom_data}),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    always_comb begin
        redirect_act = redirect_valid && (state_q != ST_IDLE);
        inst_valid   = (fifo_count != '0);
        pop          = inst_valid && inst_ready && !redirect_valid;
        // A read returning in a redirect cycle belongs to the old path and must not land.
        kill         = inflight_q && redirect_act;
        push         = inflight_q && !kill;
        // Buffered plus in-flight words may never exceed the buffer, unless a slot frees this cycle.
        has_room     = (OCC_W'(fifo_count) + OCC_W'(inflight_q)) < OCC_W'(FIFO_DEPTH);
        issue        = (state_q == ST_FETCH) && !redirect_valid && !halt_req && (has_room || pop);

        rom_en   = issue;
        rom_addr = issue ? pc_q[ADDR_W+1:2] : '0;
        inst     = inst_valid ? fifo_head[31:0]  : '0;
        inst_pc  = inst_valid ? fifo_head[63:32] : '0;
        halted   = (state_q == ST_HALTED);

        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (!redirect_act && halt_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (redirect_act) state_d = ST_FETCH;
                       else if (!inflight_q) state_d = ST_HALTED;
            ST_HALTED: if (redirect_act || !halt_req) state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase

        pc_d = pc_q;
        if (redirect_act) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if ((state_q == ST_FETCH) && !inst_valid && (perf_bubble_q != '1)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
            if (redirect_valid && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = perf_bubble_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized run scored
// against a stream model (consecutive PCs from the last redirect, ROM[i] = i).
module tb_fetch_controller;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n, rom_en, inst_valid, inst_ready, redirect_valid, halt_req, halted;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data = '0;
    logic [31:0]       inst, inst_pc, redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_bubble_cnt, perf_flush_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_controller #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    // Synchronous ROM with ROM[i] = i, one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= {{(32-ADDR_W){1'b0}}, rom_addr};
    end

    // Expected word for a byte PC: word index pc/4, wrapped to the ROM size.
    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return (pc >> 2) % (32'd1 << ADDR_W);
    endfunction

    // Holds reset for two cycles and releases it at a negedge: the caller is then in cycle 0.
    task automatic reset_dut();
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rom_en, rom_addr, inst_valid, inst, inst_pc, halted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h valid=%b inst=%h pc=%h halted=%b, want all 0",
                     rom_en, rom_addr, inst_valid, inst, inst_pc, halted);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_bubble_cnt, perf_flush_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL reset_perf: got %h/%h, want 0/0", perf_bubble_cnt, perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        reset_dut();
        inst_ready = 1'b1;
        #1; checks++;
        if (rom_en !== 1'b0) begin
            errors++; $display("FAIL cycle0_idle: rom_en=%b, want 0", rom_en);
        end
        @(negedge clk); #1; checks++;
        if ({rom_en, rom_addr} !== {1'b1, {ADDR_W{1'b0}}}) begin
            errors++; $display("FAIL cycle1_issue: rom_en=%b addr=%h, want 1/0", rom_en, rom_addr);
        end
        @(negedge clk); #1; checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL cycle2_valid: inst_valid=%b, want 0", inst_valid);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1; checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h, want valid=1 pc=%h inst=%h",
                         i, inst_valid, inst_pc, inst, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        int          issued;
        logic [31:0] exp_pc;
        reset_dut();
        inst_ready = 1'b0;
        issued = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (rom_en) issued++;
            if (i >= 3) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL hold_head[%0d]: valid=%b pc=%h, want 1/00000000", i, inst_valid, inst_pc);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (issued != DEPTH) begin
            errors++; $display("FAIL stall_issue_count: got %0d reads, want %0d", issued, DEPTH);
        end
        inst_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1; checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                errors++;
                $display("FAIL resume[%0d]: valid=%b pc=%h inst=%h, want valid=1 pc=%h", i, inst_valid, inst_pc, inst, exp_pc);
            end
            exp_pc += 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        int waited;
        reset_dut();
        inst_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b1;
        #1; checks++;
        if (inst_valid !== 1'b1 || rom_en !== 1'b0) begin
            errors++; $display("FAIL redirect_cycle: valid=%b rom_en=%b, want 1/0", inst_valid, rom_en);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1; checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL redirect_flush: inst_valid=%b, want 0", inst_valid);
        end
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== rom_word(32'h100)) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h inst=%h, want 1/00000100/%h", inst_valid, inst_pc, inst, rom_word(32'h100));
        end
        @(negedge clk); #1; checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin
            errors++; $display("FAIL redirect_next: valid=%b pc=%h, want 1/00000104", inst_valid, inst_pc);
        end
    endtask

    task automatic test_halt();
        int          waited, buffered;
        logic [31:0] exp_pc;
        reset_dut();
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
                errors++; $display("FAIL prehalt[%0d]: valid=%b pc=%h, want 1/%h", i, inst_valid, inst_pc, exp_pc);
            end
            exp_pc += 32'd4;
            @(negedge clk);
        end
        halt_req = 1'b1; inst_ready = 1'b0;
        #1;
        waited = 0;
        while (halted !== 1'b1 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL halt_reached: halted=%b after %0d cycles, want 1", halted, waited);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; checks++;
            if (rom_en !== 1'b0 || halted !== 1'b1) begin
                errors++; $display("FAIL halted_quiet[%0d]: rom_en=%b halted=%b, want 0/1", i, rom_en, halted);
            end
        end
        @(negedge clk);
        inst_ready = 1'b1;
        buffered = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            #1;
            if (inst_valid) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                    errors++; $display("FAIL halt_drain[%0d]: pc=%h inst=%h, want %h/%h", i, inst_pc, inst, exp_pc, rom_word(exp_pc));
                end
                exp_pc += 32'd4;
                buffered++;
            end
            @(negedge clk);
        end
        #1; checks++;
        if (buffered != DEPTH || inst_valid !== 1'b0 || rom_en !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_buffered: words=%0d valid=%b rom_en=%b halted=%b, want %0d/0/0/1",
                     buffered, inst_valid, rom_en, halted, DEPTH);
        end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40; halt_req = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1; checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL halt_exit: halted=%b, want 0", halted);
        end
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
            errors++; $display("FAIL halt_resume: valid=%b pc=%h, want 1/00000040", inst_valid, inst_pc);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        inst_ready = 1'b1;
        repeat (5) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1; checks++;
        if (rom_en !== 1'b1 || rom_addr !== 14'h3FFF) begin
            errors++; $display("FAIL wrap_addr_top: rom_en=%b addr=%h, want 1/3fff", rom_en, rom_addr);
        end
        @(negedge clk); #1; checks++;
        if (rom_en !== 1'b1 || rom_addr !== 14'h0) begin
            errors++; $display("FAIL wrap_addr_zero: rom_en=%b addr=%h, want 1/0000", rom_en, rom_addr);
        end
        @(negedge clk); #1; checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== rom_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_pc_top: valid=%b pc=%h inst=%h, want 1/fffffffc/%h", inst_valid, inst_pc, inst, rom_word(32'hFFFF_FFFC));
        end
        @(negedge clk); #1; checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== rom_word(32'h0)) begin
            errors++; $display("FAIL wrap_pc_zero: valid=%b pc=%h inst=%h, want 1/00000000/00000000", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_midreset();
        int waited;
        reset_dut();
        inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        #1; checks++;
        if (inst_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: inst_valid=%b, want 1", inst_valid);
        end
        @(negedge clk);
        rst_n = 1'b0; inst_ready = 1'b1;
        @(negedge clk); #1; checks++;
        if ({rom_en, rom_addr, inst_valid, inst, inst_pc, halted} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: en=%b addr=%h valid=%b inst=%h pc=%h halted=%b, want all 0",
                     rom_en, rom_addr, inst_valid, inst, inst_pc, halted);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_bubble_cnt, perf_flush_cnt} !== 64'd0) begin
            errors++; $display("FAIL midreset_perf: got %h/%h, want 0/0", perf_bubble_cnt, perf_flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 8) begin
            @(negedge clk); #1; waited++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || waited != 3) begin
            errors++; $display("FAIL midreset_restart: valid=%b pc=%h at cycle %0d, want 1/00000000 at cycle 3", inst_valid, inst_pc, waited);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_pc, prev_inst;
        logic        prev_stall;
        int          delivered;
        reset_dut();
        inst_ready = 1'b1;
        @(negedge clk);
        exp_pc = 32'h0; prev_pc = '0; prev_inst = '0; prev_stall = 1'b0; delivered = 0;
        for (int i = 0; i < 500; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            if (!halt_req && $urandom_range(0, 59) == 0) halt_req = 1'b1;
            else if (halt_req && $urandom_range(0, 7) == 0) halt_req = 1'b0;
            #1;
            if (prev_stall) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== prev_pc || inst !== prev_inst) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: valid=%b pc=%h inst=%h, want 1/%h/%h", i, inst_valid, inst_pc, inst, prev_pc, prev_inst);
                end
            end
            if (halted) begin
                checks++;
                if (rom_en !== 1'b0) begin
                    errors++; $display("FAIL rand_halted_issue[%0d]: rom_en=%b, want 0", i, rom_en);
                end
            end
            if (redirect_valid) begin
                checks++;
                if (rom_en !== 1'b0) begin
                    errors++; $display("FAIL rand_redirect_issue[%0d]: rom_en=%b, want 0", i, rom_en);
                end
                exp_pc = redirect_pc & ~32'h3;
            end else if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_deliver[%0d]: pc=%h inst=%h, want %h/%h", i, inst_pc, inst, exp_pc, rom_word(exp_pc));
                end
                $display("txn %0d pc=%h inst=%h", delivered, inst_pc, inst);
                exp_pc += 32'd4;
                delivered++;
            end
            prev_stall = inst_valid && !inst_ready && !redirect_valid;
            prev_pc    = inst_pc;
            prev_inst  = inst;
            @(negedge clk);
        end
        halt_req = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (delivered < 100) begin
            errors++; $display("FAIL rand_progress: delivered %0d, want at least 100", delivered);
        end
    endtask

    initial begin
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
